exp_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one modular exponentiation engine (16-bit x, 8-bit n, result x^n mod 2^16) among N requesters.
- Latches the winning requester's operands and pulses the engine's start.
- Tracks the engine through its busy period, then returns the result with a per-requester done pulse.
- Sits between the engine and the client blocks; the engine instance lives outside this block.

---
 rtl/exp_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_exp_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_arbiter.sv
// exp_arbiter: round-robin arbiter and sequencer sharing one external
// modular exponentiation engine (x^n mod 2^XW) among N requesters.
// Grants one job at a time, holds the engine operands for the whole busy
// period, and returns the engine result with a per-requester done pulse.
// Optional statistics (jobs_cnt, busy_wait) are built when the macro
// EXP_ARB_STATS_EN is defined; the default build omits them entirely.
module exp_arbiter #(
  parameter int N  = 4,
  parameter int XW = 16,
  parameter int NW = 8
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [N-1:0]    req,
  input  logic [N*XW-1:0] req_x,
  input  logic [N*NW-1:0] req_n,
  output logic [N-1:0]    ack,
  output logic [N-1:0]    done,
  output logic [XW-1:0]   res,
  output logic            eng_start,
  output logic [XW-1:0]   eng_inx,
  output logic [NW-1:0]   eng_inn,
  input  logic            eng_ready,
  input  logic [XW-1:0]   eng_out
`ifdef EXP_ARB_STATS_EN
  ,
  output logic [15:0]     jobs_cnt,
  output logic [N-1:0]    busy_wait
`endif
);

  // Pointer/index width; one extra bit is used while wrapping ptr+k.
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW:0] NP = (PW+1)'(N);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOW  = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_d;
  logic [PW-1:0]   cur;
  logic [PW-1:0]   cur_d;
  logic [N-1:0]    ack_d;
  logic [N-1:0]    done_d;
  logic [XW-1:0]   res_d;
  logic [XW-1:0]   inx_d;
  logic [NW-1:0]   inn_d;
  logic            start_d;

  logic [2*N-1:0]  req_dbl;
  logic [N-1:0]    req_rot;
  logic            win_found;
  logic [PW:0]     win_sum;
  logic [PW-1:0]   win_idx;
  logic [XW-1:0]   win_x;
  logic [NW-1:0]   win_n;

  // Round-robin search: rotate req so that bit 0 is requester ptr, take the
  // lowest set bit, then map the offset back to an absolute index mod N.
  always_comb begin
    req_dbl   = {req, req};
    req_rot   = N'(req_dbl >> ptr);
    win_found = |req_rot;
    win_sum   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_sum = {1'b0, ptr} + (PW+1)'(k);
      end
    end
    if (win_sum >= NP) begin
      win_sum = win_sum - NP;
    end
    win_idx = win_sum[PW-1:0];
  end

  // Operand mux: pick the winning requester's base and exponent.
  always_comb begin
    win_x = '0;
    win_n = '0;
    for (int k = 0; k < N; k++) begin
      if (win_idx == PW'(k)) begin
        win_x = req_x[k*XW +: XW];
        win_n = req_n[k*NW +: NW];
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  // Pulses (ack, done, eng_start) default low, held values default to hold.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cur_d   = cur;
    ack_d   = '0;
    done_d  = '0;
    start_d = 1'b0;
    res_d   = res;
    inx_d   = eng_inx;
    inn_d   = eng_inn;
    unique case (state)
      IDLE: begin
        if (eng_ready && win_found) begin
          inx_d   = win_x;
          inn_d   = win_n;
          start_d = 1'b1;
          ack_d   = N'(1) << win_idx;
          cur_d   = win_idx;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        // The engine must be seen busy before its ready flag means "result".
        if (!eng_ready) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (eng_ready) begin
          res_d   = eng_out;
          done_d  = N'(1) << cur;
          ptr_d   = (cur == PW'(N - 1)) ? '0 : cur + PW'(1);
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, round-robin pointer, current job and all output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      ptr       <= '0;
      cur       <= '0;
      ack       <= '0;
      done      <= '0;
      res       <= '0;
      eng_start <= 1'b0;
      eng_inx   <= '0;
      eng_inn   <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      cur       <= cur_d;
      ack       <= ack_d;
      done      <= done_d;
      res       <= res_d;
      eng_start <= start_d;
      eng_inx   <= inx_d;
      eng_inn   <= inn_d;
    end
  end

`ifdef EXP_ARB_STATS_EN
  logic [N-1:0] job_mask_d;

  // One-hot of the job that will be in flight after this edge (none in IDLE).
  always_comb begin
    job_mask_d = '0;
    if (state_d != IDLE) begin
      job_mask_d = N'(1) << cur_d;
    end
  end

  // Completed-job counter (wraps) and per-requester "waiting" flags.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      jobs_cnt  <= '0;
      busy_wait <= '0;
    end else begin
      if (|done_d) begin
        jobs_cnt <= jobs_cnt + 16'd1;
      end
      busy_wait <= req & ~ack_d & ~job_mask_d;
    end
  end
`endif

endmodule

// File: tb/tb_exp_arbiter.sv
// tb_exp_arbiter: self-checking bench for exp_arbiter with a behavioural
// engine and a transaction-level reference model of the arbiter.
module tb_exp_arbiter;
  localparam int N  = 4;
  localparam int XW = 16;
  localparam int NW = 8;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*XW-1:0] req_x = '0;
  logic [N*NW-1:0] req_n = '0;
  logic [N-1:0]    ack;
  logic [N-1:0]    done;
  logic [XW-1:0]   res;
  logic            eng_start;
  logic [XW-1:0]   eng_inx;
  logic [NW-1:0]   eng_inn;
  logic            eng_ready = 1'b1;
  logic [XW-1:0]   eng_out = '0;
`ifdef EXP_ARB_STATS_EN
  logic [15:0]     jobs_cnt;
  logic [N-1:0]    busy_wait;
`endif

  exp_arbiter #(.N(N), .XW(XW), .NW(NW)) dut (
    .clk(clk), .nrst(nrst), .req(req), .req_x(req_x), .req_n(req_n),
    .ack(ack), .done(done), .res(res), .eng_start(eng_start),
    .eng_inx(eng_inx), .eng_inn(eng_inn), .eng_ready(eng_ready),
    .eng_out(eng_out)
`ifdef EXP_ARB_STATS_EN
    , .jobs_cnt(jobs_cnt), .busy_wait(busy_wait)
`endif
  );

  always #5 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // reference model of the arbiter (job level)
  int          mptr;
  int          mcur;
  bit          mfree;
  bit          pend_done;
  logic [15:0] mres;
  logic [15:0] m_inx;
  logic [7:0]  m_inn;
  // behavioural engine
  bit          eng_busy;
  int          eng_cnt;
  int          eng_lat = 0;
  int          eng_hold = 0;
  logic [15:0] e_x;
  logic [7:0]  e_n;
  // last observed outputs
  logic [N-1:0] last_ack;
  logic [N-1:0] last_done;

  typedef struct {
    int          idx;
    logic [15:0] x;
    logic [7:0]  n;
    int          lat;
    logic [15:0] exp_res;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [15:0] powm(input logic [15:0] x, input logic [7:0] n);
    logic [31:0] r;
    r = 32'd1;
    for (int k = 0; k < int'(n); k++) r = (r * {16'd0, x}) & 32'h0000FFFF;
    return r[15:0];
  endfunction

  function automatic int rr_winner(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    mptr = 0; mcur = 0; mfree = 1'b1; pend_done = 1'b0;
    mres = '0; m_inx = '0; m_inn = '0;
    eng_busy = 1'b0; eng_cnt = 0; eng_hold = 0;
    eng_ready = 1'b1; eng_out = '0;
    last_ack = '0; last_done = '0;
  endtask

  // One clock: the values driven now are what the DUT samples at the next
  // rising edge; outputs are compared at the following falling edge.
  task automatic cycle();
    logic [N-1:0]    s_req;
    logic [N*XW-1:0] s_x;
    logic [N*NW-1:0] s_n;
    logic            s_ready;
    bit              s_free;
    logic [N-1:0]    exp_ack;
    logic [N-1:0]    exp_done;
    logic            exp_start;
    int              w;
    s_req = req; s_x = req_x; s_n = req_n; s_ready = eng_ready; s_free = mfree;
    @(negedge clk);
    exp_ack = '0; exp_done = '0; exp_start = 1'b0;
    if (s_free && s_ready && s_req != '0) begin
      w = rr_winner(s_req, mptr);
      exp_ack = N'(1 << w);
      exp_start = 1'b1;
      mfree = 1'b0;
      mcur = w;
      m_inx = s_x[w*XW +: XW];
      m_inn = s_n[w*NW +: NW];
    end
    if (pend_done) begin
      exp_done = N'(1 << mcur);
      mres = powm(m_inx, m_inn);
      mfree = 1'b1;
      mptr = (mcur + 1) % N;
      pend_done = 1'b0;
    end
    chk("ack", 32'(ack), 32'(exp_ack));
    chk("eng_start", 32'(eng_start), 32'(exp_start));
    chk("done", 32'(done), 32'(exp_done));
    chk("res", 32'(res), 32'(mres));
    chk("eng_inx", 32'(eng_inx), 32'(m_inx));
    chk("eng_inn", 32'(eng_inn), 32'(m_inn));
    last_ack = ack;
    last_done = done;
    if (eng_start && !eng_busy) begin
      e_x = eng_inx; e_n = eng_inn; eng_busy = 1'b1;
      eng_cnt = (eng_lat > 0) ? eng_lat : int'($urandom_range(5, 1));
      eng_ready = 1'b0;
      eng_out = 16'($urandom);
    end else if (eng_busy) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_busy = 1'b0; eng_ready = 1'b1;
        eng_out = powm(e_x, e_n);
        pend_done = 1'b1;
      end else begin
        eng_out = 16'($urandom);
      end
    end else if (eng_hold > 0) begin
      eng_hold--;
      if (eng_hold == 0) eng_ready = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_start", 32'(eng_start), 32'd0);
    chk("rst_inx", 32'(eng_inx), 32'd0);
    chk("rst_inn", 32'(eng_inn), 32'd0);
    model_reset();
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic set_ops(input int i, input logic [15:0] x, input logic [7:0] n);
    req_x[i*XW +: XW] = x;
    req_n[i*NW +: NW] = n;
  endtask

  task automatic drain();
    int g;
    req = '0;
    g = 0;
    while (!(mfree && !eng_busy && !pend_done) && g < 60) begin cycle(); g++; end
    chk("drain", 32'(g < 60), 32'd1);
    cycle();
  endtask

  task automatic run_job(input int i, input logic [15:0] x, input logic [7:0] n,
                         output logic [15:0] got, output int got_idx);
    int g;
    set_ops(i, x, n);
    req[i] = 1'b1;
    g = 0;
    do begin cycle(); g++; end while (last_ack[i] !== 1'b1 && g < 20);
    chk("job_ack_seen", 32'(g < 20), 32'd1);
    req[i] = 1'b0;
    g = 0;
    do begin cycle(); g++; end while (last_done == '0 && g < 40);
    chk("job_done_seen", 32'(g < 40), 32'd1);
    got = res;
    got_idx = oh_idx(last_done);
  endtask

  task automatic rr_seq(input logic [N-1:0] init_req, input int add_idx,
                        input int e0, input int e1, input int e2, input int e3);
    int order[4];
    int na, g;
    bit added;
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, 16'(i + 2), 8'(i + 1));
    req = init_req;
    na = 0; g = 0; added = 1'b0;
    while (na < 4 && g < 200) begin
      cycle(); g++;
      if (last_ack != '0) begin order[na] = oh_idx(last_ack); na++; end
      if (add_idx >= 0 && !added && last_done != '0) begin req[add_idx] = 1'b1; added = 1'b1; end
    end
    chk("rr_count", 32'(na), 32'd4);
    chk("rr_order0", 32'(order[0]), 32'(e0));
    chk("rr_order1", 32'(order[1]), 32'(e1));
    chk("rr_order2", 32'(order[2]), 32'(e2));
    chk("rr_order3", 32'(order[3]), 32'(e3));
    drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] got;
    int gi, g, c_ack1, c_done1, c_late_ack, c_done_rst;

    tbl[0] = '{0, 16'd3,      8'd5,   2, 16'h00F3};
    tbl[1] = '{1, 16'd2,      8'd10,  3, 16'h0400};
    tbl[2] = '{1, 16'h0100,   8'd2,   1, 16'h0000};
    tbl[3] = '{1, 16'd7,      8'd0,   4, 16'h0001};
    tbl[4] = '{3, 16'hFFFF,   8'd3,   2, 16'hFFFF};
    tbl[5] = '{2, 16'd3,      8'd8,   5, 16'h19A1};

    model_reset();
    do_reset();

    // single jobs from the table
    for (int t = 0; t < 6; t++) begin
      eng_lat = tbl[t].lat;
      run_job(tbl[t].idx, tbl[t].x, tbl[t].n, got, gi);
      chk("tbl_res", 32'(got), 32'(tbl[t].exp_res));
      chk("tbl_idx", 32'(gi), 32'(tbl[t].idx));
    end
    drain();

    // request dropped before ack is ignored
    eng_lat = 6;
    set_ops(0, 16'd9, 8'd2);
    req[0] = 1'b1;
    g = 0;
    do begin cycle(); g++; end while (last_ack[0] !== 1'b1 && g < 20);
    req[0] = 1'b0;
    cycle();
    set_ops(1, 16'd4, 8'd3);
    req[1] = 1'b1;
    c_ack1 = 0; c_done1 = 0; c_late_ack = 0;
    cycle(); cycle();
    req[1] = 1'b0;
    g = 0;
    do begin
      cycle(); g++;
      if (last_ack[1]) c_ack1++;
      if (last_done[1]) c_done1++;
    end while (last_done == '0 && g < 30);
    chk("drop_done0", 32'(last_done), 32'd1);
    chk("drop_res", 32'(res), 32'd81);
    repeat (5) begin
      cycle();
      if (last_ack != '0) c_late_ack++;
      if (last_done[1]) c_done1++;
    end
    chk("drop_no_ack1", 32'(c_ack1), 32'd0);
    chk("drop_no_done1", 32'(c_done1), 32'd0);
    chk("idle_quiet", 32'(c_late_ack), 32'd0);

    // reset in the middle of WAIT_DONE abandons the job
    do_reset();
    set_ops(1, 16'd5, 8'd2);
    req[1] = 1'b1;
    g = 0;
    do begin cycle(); g++; end while (last_ack[1] !== 1'b1 && g < 20);
    req[1] = 1'b0;
    repeat (3) cycle();
    set_ops(0, 16'd6, 8'd2);
    set_ops(2, 16'd8, 8'd2);
    req[0] = 1'b1; req[2] = 1'b1;
    cycle();
    do_reset();
    c_done_rst = 0;
    g = 0;
    do begin
      cycle(); g++;
      if (last_done != '0) c_done_rst++;
    end while (last_ack == '0 && g < 20);
    chk("rst_first_grant", 32'(oh_idx(last_ack)), 32'd0);
    chk("rst_no_done", 32'(c_done_rst), 32'd0);
    drain();

    // engine not ready in IDLE: no grant until it is
    eng_lat = 2;
    eng_ready = 1'b0; eng_hold = 3;
    set_ops(3, 16'd10, 8'd3);
    req[3] = 1'b1;
    g = 0;
    do begin cycle(); g++; end while (last_ack == '0 && g < 20);
    chk("hold_grant_cycles", 32'(g), 32'd4);
    req[3] = 1'b0;
    drain();

    // round-robin ordering
    eng_lat = 3;
    rr_seq(4'b0101, -1, 0, 2, 0, 2);
    rr_seq(4'b0101, 3, 0, 2, 3, 0);

`ifdef EXP_ARB_STATS_EN
    do_reset();
    chk("stats_rst", 32'(jobs_cnt), 32'd0);
    for (int t = 0; t < 3; t++) run_job(t, 16'd3, 8'd2, got, gi);
    cycle();
    chk("jobs_cnt", 32'(jobs_cnt), 32'd3);
    drain();
    do_reset();
    set_ops(0, 16'd2, 8'd2);
    set_ops(2, 16'd2, 8'd3);
    req = 4'b0101;
    g = 0;
    do begin cycle(); g++; end while (last_ack == '0 && g < 20);
    cycle(); cycle();
    chk("busy_wait2", 32'(busy_wait[2]), 32'd1);
    chk("busy_wait0", 32'(busy_wait[0]), 32'd0);
    drain();
`endif

    // randomized traffic against the reference model
    eng_lat = 0;
    for (int c = 0; c < 3000; c++) begin
      cycle();
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (last_ack[i]) begin
            if ($urandom_range(1, 0) == 1) req[i] = 1'b0;
            else set_ops(i, 16'($urandom), 8'($urandom_range(40, 0)));
          end else if ($urandom_range(49, 0) == 0) begin
            req[i] = 1'b0;
          end
        end else if ($urandom_range(3, 0) == 0) begin
          set_ops(i, 16'($urandom), 8'($urandom_range(40, 0)));
          req[i] = 1'b1;
        end
      end
      if (!eng_busy && mfree && eng_hold == 0 && $urandom_range(19, 0) == 0) begin
        eng_hold = 2; eng_ready = 1'b0;
      end
    end
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
